// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_pkg
// Brief    : Shared widths, state encoding and port ids for the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam int c_DATA_W = 64;
    localparam int c_ADDR_W = 10;

    localparam logic c_PORT0 = 1'b0;
    localparam logic c_PORT1 = 1'b1;

    // Encoding 2'd3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Two-way round-robin pick; on a tie the port that did not win last
//            time is chosen.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import mem_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |req;
        grant_id    = c_PORT0;
        if (req == 2'b11) begin
            grant_id = ~last_grant;
        end else if (req[1]) begin
            grant_id = c_PORT1;
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-requester sequencer for a single memory: round-robin grant,
//            one-cycle memory access, registered read data and ack pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [DATA_W-1:0] mem_data_in,
    output logic [ADDR_W-1:0] mem_read_adr,
    output logic [ADDR_W-1:0] mem_write_adr,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_data_out
);

    state_t              r_state,       w_state_nxt;
    logic                r_we,          w_we_nxt;
    logic                r_winner,      w_winner_nxt;
    logic                r_last_grant,  w_last_grant_nxt;
    logic [ADDR_W-1:0]   r_adr,         w_adr_nxt;
    logic [DATA_W-1:0]   r_data_in,     w_data_in_nxt;
    logic [DATA_W-1:0]   r_rdata,       w_rdata_nxt;
    logic                r_mem_rd,      w_mem_rd_nxt;
    logic                r_mem_wr,      w_mem_wr_nxt;
    logic                r_ack0,        w_ack0_nxt;
    logic                r_ack1,        w_ack1_nxt;
    logic                r_busy,        w_busy_nxt;

    logic                w_grant_valid;
    logic                w_grant_id;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_adr;
    logic [DATA_W-1:0]   w_sel_wdata;

    rr_arbiter2 u_rr_arbiter2 (
        .req         ({req1, req0}),
        .last_grant  (r_last_grant),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    assign w_sel_we    = (w_grant_id == c_PORT1) ? we1    : we0;
    assign w_sel_adr   = (w_grant_id == c_PORT1) ? addr1  : addr0;
    assign w_sel_wdata = (w_grant_id == c_PORT1) ? wdata1 : wdata0;

    always_comb begin
        w_state_nxt      = r_state;
        w_we_nxt         = r_we;
        w_winner_nxt     = r_winner;
        w_last_grant_nxt = r_last_grant;
        w_adr_nxt        = r_adr;
        w_data_in_nxt    = r_data_in;
        w_rdata_nxt      = r_rdata;
        w_mem_rd_nxt     = 1'b0;
        w_mem_wr_nxt     = 1'b0;
        w_ack0_nxt       = 1'b0;
        w_ack1_nxt       = 1'b0;
        w_busy_nxt       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_winner_nxt     = w_grant_id;
                    w_last_grant_nxt = w_grant_id;
                    w_we_nxt         = w_sel_we;
                    w_adr_nxt        = w_sel_adr;
                    // Write data is only captured on writes so the memory input stays stable otherwise.
                    if (w_sel_we) begin
                        w_data_in_nxt = w_sel_wdata;
                    end
                    w_mem_rd_nxt     = ~w_sel_we;
                    w_mem_wr_nxt     = w_sel_we;
                    w_busy_nxt       = 1'b1;
                    w_state_nxt      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!r_we) begin
                    w_rdata_nxt = mem_data_out;
                end
                w_ack0_nxt  = (r_winner == c_PORT0);
                w_ack1_nxt  = (r_winner == c_PORT1);
                w_busy_nxt  = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_winner     <= c_PORT0;
            r_last_grant <= c_PORT1;
            r_adr        <= '0;
            r_data_in    <= '0;
            r_rdata      <= '0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_we         <= w_we_nxt;
            r_winner     <= w_winner_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_adr        <= w_adr_nxt;
            r_data_in    <= w_data_in_nxt;
            r_rdata      <= w_rdata_nxt;
            r_mem_rd     <= w_mem_rd_nxt;
            r_mem_wr     <= w_mem_wr_nxt;
            r_ack0       <= w_ack0_nxt;
            r_ack1       <= w_ack1_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign ack0          = r_ack0;
    assign ack1          = r_ack1;
    assign rdata         = r_rdata;
    assign busy          = r_busy;
    assign mem_data_in   = r_data_in;
    assign mem_read_adr  = r_adr;
    assign mem_write_adr = r_adr;
    assign mem_rd        = r_mem_rd;
    assign mem_wr        = r_mem_wr;

endmodule : mem_arbiter
`default_nettype wire
